// File: rtl/pcseq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pcseq_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4,
        SEL_EXC  = 3'd5
    } next_sel_t;

    // Sign-extend the low 'width' bits of val; callers truncate to their own width.
    function automatic logic [63:0] sext64(input logic [63:0] val, input int unsigned width);
        logic [63:0] mask;
        mask = {64{1'b1}} << width;
        if (val[width-1]) begin
            sext64 = val | mask;
        end else begin
            sext64 = val & ~mask;
        end
    endfunction

endpackage

// File: rtl/pcseq_ras.sv
// Circular return-address stack: pushing while full silently overwrites the oldest entry.
// Sticky overflow/underflow flags clear only on srst_i.
module pcseq_ras
    import pcseq_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int PC_W      = 16
) (
    input  logic            clk_i,
    input  logic            srst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] data_i,
    output logic [PC_W-1:0] top_o,
    output logic            empty_o,
    output logic            full_o,
    output logic            ovf_o,
    output logic            unf_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, top_ptr_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, full_q, ovf_q, ovf_d, unf_q, unf_d;

    // wr_ptr_q is the next free slot, so the top lives one below it (mod depth).
    assign top_ptr_s = wr_ptr_q - PTR_W'(1);
    assign top_o     = mem_q[top_ptr_s];
    assign empty_o   = empty_q;
    assign full_o    = full_q;
    assign ovf_o     = ovf_q;
    assign unf_o     = unf_q;

    // Next pointer, count and sticky flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i) begin
            if (cnt_q == {CNT_W{1'b0}}) begin
                unf_d = 1'b1;
            end else begin
                wr_ptr_d = top_ptr_s;
                cnt_d    = cnt_q - CNT_W'(1);
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Pointer, count, status and sticky flag registers
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= (cnt_d == {CNT_W{1'b0}});
            full_q   <= (cnt_d == CNT_MAX);
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Entry storage; contents are meaningless once the count is reset
    always_ff @(posedge clk_i) begin
        if (push_i && !srst_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end else begin
            mem_q <= mem_q;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch/jump/call/return and a return-address stack.
// Optional exception vectoring is enabled by defining PCSEQ_EXC_VECTOR_EN.
module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter int PC_W        = 16,
    parameter int INSTR_BYTES = 2,
    parameter int BR_IMM_W    = 6,
    parameter int JMP_IMM_W   = 12,
    parameter int RAS_DEPTH   = 4
`ifdef PCSEQ_EXC_VECTOR_EN
    ,
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(16'h0010)
`endif
) (
    input  logic                 clk_pi,
    input  logic                 reset_pi,
    input  logic                 clk_en_pi,
    input  logic                 branch_taken_pi,
    input  logic [BR_IMM_W-1:0]  branch_immediate_pi,
    input  logic                 jump_taken_pi,
    input  logic                 call_taken_pi,
    input  logic [JMP_IMM_W-1:0] jump_immediate_pi,
    input  logic                 return_taken_pi,
    output logic [PC_W-1:0]      pc_po,
    output logic                 ras_empty_po,
    output logic                 ras_full_po,
    output logic                 ras_ovf_po,
    output logic                 ras_unf_po
`ifdef PCSEQ_EXC_VECTOR_EN
    ,
    input  logic                 exc_pi,
    output logic [PC_W-1:0]      epc_po
`endif
);

    next_sel_t       sel_s;
    logic [PC_W-1:0] pc_q, pc_d, nxt_s, br_off_s, jmp_off_s, ras_top_s;
    logic            exc_s, push_s, pop_s;

`ifdef PCSEQ_EXC_VECTOR_EN
    logic [PC_W-1:0] epc_q;
    assign exc_s  = exc_pi;
    assign epc_po = epc_q;
`else
    assign exc_s  = 1'b0;
`endif

    assign nxt_s     = pc_q + PC_W'(INSTR_BYTES);
    assign br_off_s  = PC_W'(sext64(64'(branch_immediate_pi), BR_IMM_W));
    assign jmp_off_s = PC_W'(sext64(64'(jump_immediate_pi), JMP_IMM_W));
    assign pc_po     = pc_q;

    // Redirect priority encoder
    always_comb begin
        sel_s = SEL_SEQ;
        if (exc_s) begin
            sel_s = SEL_EXC;
        end else if (return_taken_pi) begin
            sel_s = SEL_RET;
        end else if (call_taken_pi) begin
            sel_s = SEL_CALL;
        end else if (branch_taken_pi) begin
            sel_s = SEL_BR;
        end else if (jump_taken_pi) begin
            sel_s = SEL_JMP;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    // Next-PC mux; a return on an empty stack falls through to sequential
    always_comb begin
        pc_d = nxt_s;
        case (sel_s)
            SEL_RET:  pc_d = ras_empty_po ? nxt_s : ras_top_s;
            SEL_CALL: pc_d = nxt_s + jmp_off_s;
            SEL_BR:   pc_d = nxt_s + br_off_s;
            SEL_JMP:  pc_d = nxt_s + jmp_off_s;
`ifdef PCSEQ_EXC_VECTOR_EN
            SEL_EXC:  pc_d = EXC_VECTOR;
`endif
            default:  pc_d = nxt_s;
        endcase
    end

    assign push_s = clk_en_pi && (sel_s == SEL_CALL);
    assign pop_s  = clk_en_pi && (sel_s == SEL_RET);

    pcseq_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk_i   (clk_pi),
        .srst_i  (reset_pi),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (nxt_s),
        .top_o   (ras_top_s),
        .empty_o (ras_empty_po),
        .full_o  (ras_full_po),
        .ovf_o   (ras_ovf_po),
        .unf_o   (ras_unf_po)
    );

    // PC register (reset wins over the advance enable)
    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            pc_q <= {PC_W{1'b0}};
        end else if (clk_en_pi) begin
            pc_q <= pc_d;
        end else begin
            pc_q <= pc_q;
        end
    end

`ifdef PCSEQ_EXC_VECTOR_EN
    // Exception PC capture
    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            epc_q <= {PC_W{1'b0}};
        end else if (clk_en_pi && exc_s) begin
            epc_q <= pc_q;
        end else begin
            epc_q <= epc_q;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model pushes expected state per cycle,
// which is popped and compared one clock later. Exception checks need PCSEQ_EXC_VECTOR_EN.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, clk_en, br, jmp, call, ret;
    logic [5:0]  bimm;
    logic [11:0] jimm;
    logic [15:0] pc;
    logic        emp, full, ovf, unf;
    logic        exc;
    logic [15:0] epc;

    typedef struct packed {
        logic [15:0] pc;
        logic        emp;
        logic        full;
        logic        ovf;
        logic        unf;
        logic [15:0] epc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_stk[$];
    logic [15:0] m_pc, m_epc;
    logic        m_ovf, m_unf;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk_pi              (clk),
        .reset_pi            (reset),
        .clk_en_pi           (clk_en),
        .branch_taken_pi     (br),
        .branch_immediate_pi (bimm),
        .jump_taken_pi       (jmp),
        .call_taken_pi       (call),
        .jump_immediate_pi   (jimm),
        .return_taken_pi     (ret),
        .pc_po               (pc),
        .ras_empty_po        (emp),
        .ras_full_po         (full),
        .ras_ovf_po          (ovf),
        .ras_unf_po          (unf)
`ifdef PCSEQ_EXC_VECTOR_EN
        ,
        .exc_pi              (exc),
        .epc_po              (epc)
`endif
    );

`ifndef PCSEQ_EXC_VECTOR_EN
    assign epc = 16'h0000;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one cycle, advance the model, push expectation, then pop and compare after the edge.
    task automatic step(input logic r, input logic e, input logic x, input logic rt,
                        input logic c, input logic b, input logic j,
                        input logic [5:0] bi, input logic [11:0] ji);
        logic [15:0] nxt;
        exp_t        ex;
        reset = r; clk_en = e; exc = x; ret = rt; call = c; br = b; jmp = j;
        bimm = bi; jimm = ji;
        if (r) begin
            m_pc = 16'h0000; m_epc = 16'h0000; m_ovf = 1'b0; m_unf = 1'b0;
            m_stk.delete();
        end else if (e) begin
            nxt = m_pc + 16'd2;
            if (x) begin
                m_epc = m_pc;
                m_pc  = 16'h0010;
            end else if (rt) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = nxt; m_unf = 1'b1; end
            end else if (c) begin
                if (m_stk.size() == 4) begin void'(m_stk.pop_front()); m_ovf = 1'b1; end
                m_stk.push_back(nxt);
                m_pc = nxt + {{4{ji[11]}}, ji};
            end else if (b) m_pc = nxt + {{10{bi[5]}}, bi};
            else if (j) m_pc = nxt + {{4{ji[11]}}, ji};
            else m_pc = nxt;
        end
        ex.pc = m_pc; ex.emp = (m_stk.size() == 0); ex.full = (m_stk.size() == 4);
        ex.ovf = m_ovf; ex.unf = m_unf; ex.epc = m_epc;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            ex = sb_q.pop_front();
            check_eq("pc", 32'(pc), 32'(ex.pc));
            check_eq("empty", 32'(emp), 32'(ex.emp));
            check_eq("full", 32'(full), 32'(ex.full));
            check_eq("ovf", 32'(ovf), 32'(ex.ovf));
            check_eq("unf", 32'(unf), 32'(ex.unf));
`ifdef PCSEQ_EXC_VECTOR_EN
            check_eq("epc", 32'(epc), 32'(ex.epc));
`endif
        end
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 12'h000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; clk_en = 1'b0; exc = 1'b0; ret = 1'b0; call = 1'b0;
        br = 1'b0; jmp = 1'b0; bimm = 6'h00; jimm = 12'h000;
        m_pc = 16'h0000; m_epc = 16'h0000; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset, sequential run, hold with clk_en low
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 12'h000);
        check_eq("rst_pc", 32'(pc), 32'd0);
        check_eq("rst_empty", 32'(emp), 32'd1);
        seq(4);
        check_eq("seq_pc8", 32'(pc), 32'd8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 12'h000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h3E, 12'h00A);
        check_eq("hold_pc8", 32'(pc), 32'd8);

        // Backward branch, then branch beating jump
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h3E, 12'h000);
        check_eq("br_back", 32'(pc), 32'd8);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h3E, 12'h00A);
        check_eq("br_over_jmp", 32'(pc), 32'd8);

        // Call and return
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 12'h000);
        seq(2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 12'h00A);
        check_eq("call_pc", 32'(pc), 32'd16);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 12'h000);
        check_eq("ret_pc", 32'(pc), 32'd6);
        check_eq("ret_empty", 32'(emp), 32'd1);

        // Five nested calls overflow a depth-4 stack; five returns underflow
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 12'h000);
        check_eq("ovf_set", 32'(ovf), 32'd1);
        check_eq("full_set", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 12'h000);
            check_eq("lifo", 32'(pc), 32'(16 - 2 * i));
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 12'h000);
        check_eq("unf_pc", 32'(pc), 32'd12);
        check_eq("unf_set", 32'(unf), 32'd1);

        // Wrap-around, then reset while disabled clears the stack
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 12'h000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 12'hFFC);
        check_eq("pc_fffe", 32'(pc), 32'hFFFE);
        seq(1);
        check_eq("pc_wrap", 32'(pc), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 12'h010);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 12'h000);
        check_eq("rst_noen_pc", 32'(pc), 32'd0);
        check_eq("rst_noen_empty", 32'(emp), 32'd1);

`ifdef PCSEQ_EXC_VECTOR_EN
        // Exception overrides a return and leaves the stack alone
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 12'h010);
        seq(1);
        check_eq("pc20", 32'(pc), 32'd20);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 12'h000);
        check_eq("exc_pc", 32'(pc), 32'h0010);
        check_eq("exc_epc", 32'(epc), 32'd20);
        check_eq("exc_ras", 32'(emp), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 12'h000);
        check_eq("exc_ret", 32'(pc), 32'd2);
`endif

        // Randomised mix against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 7) != 0,
`ifdef PCSEQ_EXC_VECTOR_EN
                 $urandom_range(0, 15) == 0,
`else
                 1'b0,
`endif
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 6'($urandom), 12'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
